// File: rtl/alu_issue.sv
// alu_issue: decodes one RV32I integer/branch instruction per cycle into an
// ALU operation and holds it in a single valid/ready output register that
// supports back-to-back issue, downstream stall and flush.

`ifndef ALU_ISSUE_DEFS
`define ALU_ISSUE_DEFS
`define ALU_INST_BUS     3:0
`define ALU_ADD          4'd0
`define ALU_SUB          4'd1
`define ALU_LL           4'd2
`define ALU_RL           4'd3
`define ALU_ARL          4'd4
`define ALU_XOR          4'd5
`define ALU_OR           4'd6
`define ALU_AND          4'd7
`define ALU_CMP_EQ       4'd8
`define ALU_CMP_NEQ      4'd9
`define ALU_CMP_LESS     4'd10
`define ALU_CMP_LESSU    4'd11
`define ALU_CMP_MORE_EQ  4'd12
`define ALU_CMP_MORE_EQU 4'd13
`endif

module alu_issue (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid_i,
    output logic                 inst_ready_o,
    input  logic [31:0]          inst_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          rs1_data_i,
    input  logic [31:0]          rs2_data_i,
    input  logic                 flush_i,
    output logic                 alu_valid_o,
    input  logic                 alu_ready_i,
    output logic [`ALU_INST_BUS] alu_inst_o,
    output logic [31:0]          alu_src1_o,
    output logic [31:0]          alu_src2_o,
    output logic [4:0]           rd_o,
    output logic                 rd_we_o,
    output logic                 is_branch_o,
    output logic [31:0]          branch_target_o,
    output logic                 illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          imm_i;
    logic [31:0]          imm_u;
    logic [31:0]          imm_b;
    logic [31:0]          shamt;

    logic [`ALU_INST_BUS] raw_op;
    logic [31:0]          raw_src1;
    logic [31:0]          raw_src2;
    logic                 raw_legal;
    logic                 raw_writes;
    logic                 raw_branch;

    logic [`ALU_INST_BUS] dec_op;
    logic [31:0]          dec_src1;
    logic [31:0]          dec_src2;
    logic [4:0]           dec_rd;
    logic                 dec_rd_we;
    logic                 dec_branch;
    logic [31:0]          dec_target;
    logic                 dec_illegal;

    logic                 accept;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign shamt  = {27'b0, inst_i[24:20]};

    // A new instruction can enter only when the output slot is empty or being drained, and never during a flush.
    assign inst_ready_o = !flush_i && (!alu_valid_o || alu_ready_i);
    assign accept       = inst_valid_i && inst_ready_o;

    // Raw opcode/funct decode into operation, operands and legality.
    always_comb begin
        raw_op     = `ALU_ADD;
        raw_src1   = 32'd0;
        raw_src2   = 32'd0;
        raw_legal  = 1'b0;
        raw_writes = 1'b0;
        raw_branch = 1'b0;
        case (opcode)
            OPC_OP: begin
                raw_src1   = rs1_data_i;
                raw_src2   = rs2_data_i;
                raw_writes = 1'b1;
                raw_legal  = (funct7 == F7_ZERO) ||
                             ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                case (funct3)
                    3'b000:  raw_op = funct7[5] ? `ALU_SUB : `ALU_ADD;
                    3'b001:  raw_op = `ALU_LL;
                    3'b010:  raw_op = `ALU_CMP_LESS;
                    3'b011:  raw_op = `ALU_CMP_LESSU;
                    3'b100:  raw_op = `ALU_XOR;
                    3'b101:  raw_op = funct7[5] ? `ALU_ARL : `ALU_RL;
                    3'b110:  raw_op = `ALU_OR;
                    default: raw_op = `ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                raw_src1   = rs1_data_i;
                raw_src2   = imm_i;
                raw_writes = 1'b1;
                raw_legal  = 1'b1;
                case (funct3)
                    3'b000:  raw_op = `ALU_ADD;
                    3'b001: begin
                        raw_op    = `ALU_LL;
                        raw_src2  = shamt;
                        raw_legal = (funct7 == F7_ZERO);
                    end
                    3'b010:  raw_op = `ALU_CMP_LESS;
                    3'b011:  raw_op = `ALU_CMP_LESSU;
                    3'b100:  raw_op = `ALU_XOR;
                    3'b101: begin
                        raw_op    = inst_i[30] ? `ALU_ARL : `ALU_RL;
                        raw_src2  = shamt;
                        raw_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b110:  raw_op = `ALU_OR;
                    default: raw_op = `ALU_AND;
                endcase
            end
            OPC_LUI: begin
                raw_src2   = imm_u;
                raw_writes = 1'b1;
                raw_legal  = 1'b1;
            end
            OPC_AUIPC: begin
                raw_src1   = pc_i;
                raw_src2   = imm_u;
                raw_writes = 1'b1;
                raw_legal  = 1'b1;
            end
            OPC_BRANCH: begin
                raw_src1   = rs1_data_i;
                raw_src2   = rs2_data_i;
                raw_branch = 1'b1;
                raw_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
                case (funct3)
                    3'b000:  raw_op = `ALU_CMP_EQ;
                    3'b001:  raw_op = `ALU_CMP_NEQ;
                    3'b100:  raw_op = `ALU_CMP_LESS;
                    3'b101:  raw_op = `ALU_CMP_MORE_EQ;
                    3'b110:  raw_op = `ALU_CMP_LESSU;
                    3'b111:  raw_op = `ALU_CMP_MORE_EQU;
                    default: raw_op = `ALU_ADD;
                endcase
            end
            default: begin
                raw_legal = 1'b0;
            end
        endcase
    end

    // Illegal encodings collapse to a harmless add of zeros with no side effects.
    always_comb begin
        dec_op      = `ALU_ADD;
        dec_src1    = 32'd0;
        dec_src2    = 32'd0;
        dec_rd      = 5'd0;
        dec_rd_we   = 1'b0;
        dec_branch  = 1'b0;
        dec_target  = 32'd0;
        dec_illegal = !raw_legal;
        if (raw_legal) begin
            dec_op     = raw_op;
            dec_src1   = raw_src1;
            dec_src2   = raw_src2;
            dec_rd_we  = raw_writes && (inst_i[11:7] != 5'd0);
            dec_rd     = raw_writes ? inst_i[11:7] : 5'd0;
            dec_branch = raw_branch;
            dec_target = raw_branch ? (pc_i + imm_b) : 32'd0;
        end
    end

    // Output slot: flush empties it, accept (re)loads it, consume without accept empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid_o     <= 1'b0;
            alu_inst_o      <= '0;
            alu_src1_o      <= 32'd0;
            alu_src2_o      <= 32'd0;
            rd_o            <= 5'd0;
            rd_we_o         <= 1'b0;
            is_branch_o     <= 1'b0;
            branch_target_o <= 32'd0;
            illegal_o       <= 1'b0;
        end else if (flush_i) begin
            alu_valid_o     <= 1'b0;
        end else if (accept) begin
            alu_valid_o     <= 1'b1;
            alu_inst_o      <= dec_op;
            alu_src1_o      <= dec_src1;
            alu_src2_o      <= dec_src2;
            rd_o            <= dec_rd;
            rd_we_o         <= dec_rd_we;
            is_branch_o     <= dec_branch;
            branch_target_o <= dec_target;
            illegal_o       <= dec_illegal;
        end else if (alu_ready_i) begin
            alu_valid_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a
// table-driven reference decoder and a one-slot handshake model.

module tb_alu_issue;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, LL = 4'd2, RL = 4'd3, ARL = 4'd4;
    localparam logic [3:0] XOR_ = 4'd5, OR_ = 4'd6, AND_ = 4'd7;
    localparam logic [3:0] EQ = 4'd8, NEQ = 4'd9, LESS = 4'd10, LESSU = 4'd11;
    localparam logic [3:0] MORE_EQ = 4'd12, MORE_EQU = 4'd13;

    // Register-register table: legal (funct7, funct3) pairs and their operation.
    localparam int         OP_F7 [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    localparam int         OP_F3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    localparam logic [3:0] OP_OP [10] = '{ADD, SUB, LL, LESS, LESSU, XOR_, RL, ARL, OR_, AND_};
    // Immediate table: funct7 of -1 means the upper bits are immediate, not checked.
    localparam int         IM_F3 [9] = '{0, 1, 2, 3, 4, 5, 5, 6, 7};
    localparam int         IM_F7 [9] = '{-1, 0, -1, -1, -1, 0, 32, -1, -1};
    localparam logic [3:0] IM_OP [9] = '{ADD, LL, LESS, LESSU, XOR_, RL, ARL, OR_, AND_};
    // Branch table.
    localparam int         BR_F3 [6] = '{0, 1, 4, 5, 6, 7};
    localparam logic [3:0] BR_OP [6] = '{EQ, NEQ, LESS, MORE_EQ, LESSU, MORE_EQU};

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic [31:0] tgt;
        logic        ill;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic [3:0]  alu_inst_o;
    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic        is_branch_o;
    logic [31:0] branch_target_o;
    logic        illegal_o;

    int   checks = 0;
    int   errors = 0;
    logic modelValid = 1'b0;
    pay_t modelPay;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .flush_i(flush_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .alu_inst_o(alu_inst_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .rd_o(rd_o), .rd_we_o(rd_we_o),
        .is_branch_o(is_branch_o), .branch_target_o(branch_target_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // Reference decoder: table lookups plus plain arithmetic on immediates.
    function automatic pay_t refModel(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
        pay_t p;
        int   f3;
        int   f7;
        int   off;
        logic writes;
        f3 = int'(inst[14:12]);
        f7 = int'(inst[31:25]);
        p = '0;
        p.op = ADD;
        p.ill = 1'b1;
        writes = 1'b0;
        if (inst[6:0] == 7'h33) begin
            for (int k = 0; k < 10; k++)
                if (f7 == OP_F7[k] && f3 == OP_F3[k]) begin
                    p.ill = 1'b0; p.op = OP_OP[k];
                end
            if (!p.ill) begin p.s1 = a; p.s2 = b; writes = 1'b1; end
        end else if (inst[6:0] == 7'h13) begin
            for (int k = 0; k < 9; k++)
                if (f3 == IM_F3[k] && (IM_F7[k] < 0 || f7 == IM_F7[k])) begin
                    p.ill = 1'b0; p.op = IM_OP[k];
                end
            if (!p.ill) begin
                p.s1 = a;
                p.s2 = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : $unsigned($signed(inst) >>> 20);
                writes = 1'b1;
            end
        end else if (inst[6:0] == 7'h37 || inst[6:0] == 7'h17) begin
            p.ill = 1'b0;
            p.s1 = (inst[6:0] == 7'h17) ? pc : 32'd0;
            p.s2 = inst & 32'hFFFFF000;
            writes = 1'b1;
        end else if (inst[6:0] == 7'h63) begin
            for (int k = 0; k < 6; k++)
                if (f3 == BR_F3[k]) begin p.ill = 1'b0; p.op = BR_OP[k]; end
            if (!p.ill) begin
                off = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 +
                      int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
                p.s1 = a; p.s2 = b; p.br = 1'b1;
                p.tgt = pc + 32'(off);
            end
        end
        p.we = writes && (inst[11:7] != 5'd0);
        p.rd = writes ? inst[11:7] : 5'd0;
        return p;
    endfunction

    // Random instruction biased toward the decodable classes.
    function automatic logic [31:0] randInst();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0, 1:    r[31:25] = 7'h00;
                    2:       r[31:25] = 7'h20;
                    default: ;
                endcase
            end
            1: begin
                r[6:0] = 7'h13;
                if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            2:       r[6:0] = 7'h37;
            3:       r[6:0] = 7'h17;
            4:       r[6:0] = 7'h63;
            default: ;
        endcase
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("alu_valid", alu_valid_o, modelValid);
        if (modelValid) begin
            checkVal("alu_inst", alu_inst_o, modelPay.op);
            checkVal("src1", alu_src1_o, modelPay.s1);
            checkVal("src2", alu_src2_o, modelPay.s2);
            checkVal("rd", rd_o, modelPay.rd);
            checkVal("rd_we", rd_we_o, modelPay.we);
            checkVal("is_branch", is_branch_o, modelPay.br);
            checkVal("branch_target", branch_target_o, modelPay.tgt);
            checkVal("illegal", illegal_o, modelPay.ill);
        end
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, "_valid"}, alu_valid_o, 0);
        checkVal({tag, "_payload"}, {alu_inst_o, rd_o, rd_we_o, is_branch_o, illegal_o}, 0);
        checkVal({tag, "_src1"}, alu_src1_o, 0);
        checkVal({tag, "_src2"}, alu_src2_o, 0);
        checkVal({tag, "_target"}, branch_target_o, 0);
    endtask

    // One clock cycle: drive, check ready, advance the model at the edge, check outputs.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic rdy, input logic fl);
        logic expReady;
        inst_valid_i = v;
        inst_i       = inst;
        pc_i         = pc;
        rs1_data_i   = a;
        rs2_data_i   = b;
        alu_ready_i  = rdy;
        flush_i      = fl;
        #1;
        expReady = !fl && (!modelValid || rdy);
        checkVal("inst_ready", inst_ready_o, expReady);
        @(posedge clk);
        if (fl) modelValid = 1'b0;
        else if (v && expReady) begin
            modelValid = 1'b1;
            modelPay   = refModel(inst, pc, a, b);
        end else if (rdy) modelValid = 1'b0;
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        inst_valid_i = 0; inst_i = 0; pc_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        flush_i = 0; alu_ready_i = 0;
        modelPay = '0;
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset");
        rst = 1'b0;
        #1;
        checkVal("ready_after_reset", inst_ready_o, 1);

        // ADD x3,x1,x2
        applyStimulus(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);
        checkVal("add_op", alu_inst_o, ADD);
        checkVal("add_src1", alu_src1_o, 5);
        checkVal("add_src2", alu_src2_o, 7);
        checkVal("add_rd", rd_o, 3);
        // SRAI x5,x6,4
        applyStimulus(1, 32'h40435293, 32'h4, 32'h80000000, 32'h0, 1, 0);
        checkVal("srai_op", alu_inst_o, ARL);
        checkVal("srai_src2", alu_src2_o, 4);
        // ADDI x1,x0,-1
        applyStimulus(1, 32'hFFF00093, 32'h8, 32'h0, 32'h0, 1, 0);
        checkVal("addi_src2", alu_src2_o, 32'hFFFFFFFF);
        // BLTU at 0x100, offset -8
        applyStimulus(1, 32'hFE20ECE3, 32'h100, 32'd1, 32'd2, 1, 0);
        checkVal("bltu_op", alu_inst_o, LESSU);
        checkVal("bltu_target", branch_target_o, 32'h000000F8);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // Three back-to-back instructions with a two-cycle downstream stall.
        applyStimulus(1, 32'h00100093, 32'h200, 32'd1, 32'd0, 0, 0);
        applyStimulus(1, 32'h00200113, 32'h204, 32'd2, 32'd0, 0, 0);
        checkVal("stall_hold_rd", rd_o, 1);
        applyStimulus(1, 32'h00200113, 32'h204, 32'd2, 32'd0, 0, 0);
        applyStimulus(1, 32'h00200113, 32'h204, 32'd2, 32'd0, 1, 0);
        checkVal("order_second_rd", rd_o, 2);
        applyStimulus(1, 32'h00300193, 32'h208, 32'd3, 32'd0, 1, 0);
        checkVal("order_third_rd", rd_o, 3);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // Held operation flushed while a new one is offered.
        applyStimulus(1, 32'h002081B3, 32'h300, 32'd9, 32'd9, 0, 0);
        applyStimulus(1, 32'h00408233, 32'h304, 32'd4, 32'd4, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset asserted asynchronously in the middle of a stall.
        applyStimulus(1, 32'h002081B3, 32'h400, 32'd5, 32'd6, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checkZero("async_reset");
        modelValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkVal("ready_after_mid_reset", inst_ready_o, 1);

        // Unknown opcode and bad funct7 issue as illegal through the handshake.
        applyStimulus(1, 32'h0000007F, 32'h500, 32'd1, 32'd1, 1, 0);
        checkVal("bad_opcode_illegal", illegal_o, 1);
        applyStimulus(1, 32'h022081B3, 32'h504, 32'd1, 32'd1, 1, 0);
        checkVal("bad_funct7_illegal", illegal_o, 1);
        checkVal("bad_funct7_rd_we", rd_we_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic with stalls, bubbles and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInst(), $urandom, $urandom, $urandom,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
